// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the rPLL reset, waits for a filtered lock, then releases
// the downstream system reset; drops back to PLL reset if lock is lost in RUN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 20,
  parameter int PLL_RST_CYCLES = 27,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int LOCK_FILTER    = 16,
  parameter int HOLD_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic [3:0] loss_count
);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       loss_q, loss_d;
  logic             pll_rst_q, sys_rst_q, ready_q;

  // lock comes straight from the PLL with no relation to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // lock wins over a timeout landing on the same cycle
        if (lock_s) begin
          state_d = FILTER;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          loss_d  = (loss_q == 4'hF) ? loss_q : loss_q + 4'd1;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 4'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == PLL_RESET);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

PLL supervisor and reset generator; it consumes the rPLL's `lock` output and drives the rPLL's `RESET` input. It runs on the 27 MHz board clock, which is independent of the PLL. It holds the video pipeline in reset until the PLL has shown stable lock, re-pulses the PLL reset when lock does not arrive in time, and re-asserts the system reset when lock is lost. `sys_rst` is synchronous to `clk`; consumers in the pixel and TMDS domains re-synchronize it locally.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — synchronizer depth on `lock`; minimum 2.
- `CNT_W`, 20 — width of the shared cycle counter. Every count parameter must be ≤ 2^CNT_W.
- `PLL_RST_CYCLES`, 27 — cycles `pll_rst` is held per pulse (1 µs).
- `LOCK_TIMEOUT`, 270000 — cycles to wait for lock before retrying (10 ms).
- `LOCK_FILTER`, 16 — consecutive synchronized-lock cycles required.
- `HOLD_CYCLES`, 64 — extra `sys_rst` hold cycles after the filter passes.

Ports:
- `clk`  in  1 — 27 MHz board clock.
- `rst`  in  1 — asynchronous, active-high reset.
- `lock`  in  1 — rPLL LOCK; asynchronous to `clk`.
- `pll_rst`  out  1 — to rPLL RESET; active high.
- `sys_rst`  out  1 — downstream reset; active high.
- `ready`  out  1 — high only in RUN.
- `state`  out  3 — current state code.
- `retry_count`  out  4 — number of lock timeouts; saturates at 15.
- `loss_count`  out  4 — number of lock losses from RUN; saturates at 15.

## Operation
- **Lock input:** `lock` passes through `SYNC_STAGES` flops to produce `lock_s`. The synchronizer flops clear to 0 on reset.
- **Counter:** one `CNT_W`-bit counter `cnt`, cleared on every state entry.
- **State codes:** PLL_RESET=0, WAIT_LOCK=1, FILTER=2, HOLD=3, RUN=4. Codes 5–7 are unreachable and go to PLL_RESET.
- **PLL_RESET:**
  - `lock_s` is ignored.
  - If `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK; otherwise increment `cnt`.
- **WAIT_LOCK:**
  - If `lock_s == 1`, go to FILTER.
  - Else if `cnt == LOCK_TIMEOUT-1`, go to PLL_RESET and increment `retry_count` (saturating).
  - Otherwise increment `cnt`.
- **FILTER:**
  - If `lock_s == 0`, go to WAIT_LOCK. The timeout restarts from 0.
  - Else if `cnt == LOCK_FILTER-1`, go to HOLD.
  - Otherwise increment `cnt`.
- **HOLD:**
  - If `lock_s == 0`, go to WAIT_LOCK. `loss_count` is not incremented.
  - Else if `cnt == HOLD_CYCLES-1`, go to RUN.
  - Otherwise increment `cnt`.
- **RUN:** if `lock_s == 0`, go to PLL_RESET and increment `loss_count` (saturating). Otherwise stay in RUN.
- **Outputs:**
  - All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
  - `pll_rst = (state == PLL_RESET)`.
  - `sys_rst = (state != RUN)`.
  - `ready = (state == RUN)`.
- **Reset values:** state=PLL_RESET, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `retry_count`=0, `loss_count`=0.
- **Reset mid-operation:** asserting `rst` in any state forces all reset values immediately, without waiting for a clock edge. The counters are cleared.
- **Simultaneous events:** a timeout and `lock_s` rising on the same cycle resolve to FILTER, because lock has priority.

## Timing
- **Start-up `pll_rst`:** after `rst` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges and falls on the `PLL_RST_CYCLES`-th edge.
- **Lock to RUN:** number edges from the first edge that samples `lock=1` while in WAIT_LOCK (edge 0).
  - FILTER is entered at edge `SYNC_STAGES`.
  - HOLD is entered at edge `SYNC_STAGES+LOCK_FILTER`.
  - `sys_rst` falls and `ready` rises at edge `SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES`; this is edge 82 with default parameters.
- **Loss of lock from RUN:** number edges from the first edge that samples `lock=0` (edge 0). At edge `SYNC_STAGES`, `sys_rst`=1, `pll_rst`=1 and `ready`=0, all on the same edge.
- **Retry period with no lock:** `PLL_RST_CYCLES+LOCK_TIMEOUT` cycles.
- **Glitch rejection:** a `lock` pulse shorter than `LOCK_FILTER` cycles never deasserts `sys_rst`.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_FILTER=3, HOLD_CYCLES=5, SYNC_STAGES=2.
- **Normal start:** release `rst`; raise `lock` 2 cycles after `pll_rst` falls.
  - `pll_rst` is high for 4 edges.
  - `sys_rst` falls and `ready` rises 10 edges after `lock` is first sampled.
  - `state` sequence: 0, 1, 2, 3, 4.
- **No lock:** hold `lock`=0.
  - `pll_rst` re-pulses for 4 cycles every 24 cycles.
  - `retry_count` increments 1, 2, … and saturates at 15.
  - `sys_rst` stays 1 throughout.
- **Glitch:** raise `lock` for 2 cycles while in WAIT_LOCK.
  - `state` goes 1→2→1.
  - `sys_rst` stays 1.
  - A later stable `lock` still needs the full 3+5 cycles.
- **Loss in RUN:** from RUN, drop `lock`.
  - Two edges later: `state`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `loss_count`=1.
  - Restoring `lock` returns to RUN with the normal-start timing.
- **Loss in HOLD:** drop `lock` in the middle of HOLD.
  - `state` returns to 1.
  - `loss_count` is unchanged and `pll_rst` stays 0.
- **Asynchronous reset:** assert `rst` between edges while in RUN with nonzero counts.
  - Immediately: `pll_rst`=1, `sys_rst`=1, `ready`=0, `state`=0, both counts 0.
